// File: rtl/sram_write_ctrl.sv
// Drains 32-bit words from the mover FIFO and writes them as a fixed-length
// burst into an asynchronous SRAM, one WAIT/RD/LAT/WR/HOLD sequence per word.
module sram_write_ctrl #(
  parameter int BURST_LEN = 1024,
  parameter int WE_CYC    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [23:0] sram_waddr,
  input  logic [31:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [23:0] sram_addr,
  output logic [31:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        busy,
  output logic        done,
  output logic        req_drop,
  output logic [2:0]  o_state
);

  localparam int              CNT_W     = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);
  localparam logic [3:0]      WE_LAST   = 4'(WE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_RD   = 3'd2,
    S_LAT  = 3'd3,
    S_WR   = 3'd4,
    S_HOLD = 3'd5,
    S_FIN  = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic             req_q;
  logic [23:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       we_cnt_q, we_cnt_d;
  logic             req_rise;

  assign req_rise = wr_req & ~req_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      we_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      req_q    <= wr_req;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      we_cnt_q <= we_cnt_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    we_cnt_d = we_cnt_q;
    case (state_q)
      S_IDLE: if (req_rise) begin
        addr_d  = sram_waddr;
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: if (!fifo_empty) state_d = S_RD;
      S_RD:   state_d = S_LAT;
      S_LAT: begin
        data_d   = fifo_dout;
        we_cnt_d = '0;
        state_d  = S_WR;
      end
      S_WR: begin
        if (we_cnt_q == WE_LAST) state_d = S_HOLD;
        else                     we_cnt_d = we_cnt_q + 4'd1;
      end
      S_HOLD: begin
        addr_d  = addr_q + 24'd1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == LAST_WORD) ? S_FIN : S_WAIT;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  logic drive;
  assign drive = (state_q == S_LAT) || (state_q == S_WR) || (state_q == S_HOLD);

  // Fresh FIFO data is forwarded during LAT so it is stable before WE falls.
  assign sram_dq_o  = (state_q == S_LAT) ? fifo_dout : data_q;
  assign sram_addr  = addr_q;
  assign sram_dq_oe = drive;
  assign sram_ce_n  = ~drive;
  assign sram_we_n  = (state_q != S_WR);
  assign sram_oe_n  = 1'b1;
  assign fifo_rd_en = (state_q == S_RD);
  assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done       = (state_q == S_FIN);
  assign req_drop   = req_rise && (state_q != S_IDLE);
  assign o_state    = state_q;

endmodule
